// File: rtl/gpio_pkg.sv
// Shared definitions for the gpio_bank register map.
// GPIO_OFF_DEB is decoded only when GPIO_DEBOUNCE_EN is defined.
package gpio_pkg;

    localparam int GPIO_ADDR_WIDTH = 4;

    localparam logic [31:0] GPIO_OFF_IN       = 32'd0;
    localparam logic [31:0] GPIO_OFF_OUT      = 32'd1;
    localparam logic [31:0] GPIO_OFF_DIR      = 32'd2;
    localparam logic [31:0] GPIO_OFF_OUT_SET  = 32'd3;
    localparam logic [31:0] GPIO_OFF_OUT_CLR  = 32'd4;
    localparam logic [31:0] GPIO_OFF_OUT_TGL  = 32'd5;
    localparam logic [31:0] GPIO_OFF_IRQ_EN   = 32'd6;
    localparam logic [31:0] GPIO_OFF_IRQ_RISE = 32'd7;
    localparam logic [31:0] GPIO_OFF_IRQ_FALL = 32'd8;
    localparam logic [31:0] GPIO_OFF_IRQ_STAT = 32'd9;
    localparam logic [31:0] GPIO_OFF_DEB      = 32'd10;

endpackage

// File: rtl/gpio_sync_edge.sv
// Pad input synchroniser with rise/fall detection for a whole bank.
// GPIO_DEBOUNCE_EN inserts a per-pin debounce filter between the synchroniser and the edge detector.
module gpio_sync_edge #(
    parameter int DATA_WIDTH     = 16,
    parameter int DEBOUNCE_WIDTH = 8
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [DATA_WIDTH-1:0]     gpin,
`ifdef GPIO_DEBOUNCE_EN
    input  logic [DEBOUNCE_WIDTH-1:0] deb_limit,
`endif
    output logic [DATA_WIDTH-1:0]     level,
    output logic [DATA_WIDTH-1:0]     rise,
    output logic [DATA_WIDTH-1:0]     fall
);

    logic [DATA_WIDTH-1:0] meta;
    logic [DATA_WIDTH-1:0] sync;
    logic [DATA_WIDTH-1:0] del;

    // NOTE: non-blocking assignments so every flop samples the pre-edge value of its source.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            meta <= '0;
            sync <= '0;
            del  <= '0;
        end else begin
            meta <= gpin;
            sync <= meta;
            del  <= level;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    logic [DEBOUNCE_WIDTH-1:0] cnt [DATA_WIDTH];
    logic [DATA_WIDTH-1:0]     flt;

    // NOTE: the counter array is a plain register file, so it is cleared element by element in reset.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            flt <= '0;
            for (int i = 0; i < DATA_WIDTH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (sync[i] != flt[i]) begin
                    if (cnt[i] == deb_limit) begin
                        flt[i] <= sync[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + DEBOUNCE_WIDTH'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign level = flt;
`else
    assign level = sync;
`endif

    assign rise = level & ~del;
    assign fall = ~level & del;

endmodule

// File: rtl/gpio_bank.sv
// Parametrised GPIO bank: bus decode, output/direction registers, edge interrupts and irq.
// Define GPIO_DEBOUNCE_EN to add per-pin input debouncing and the DEB_LIMIT register.
module gpio_bank
    import gpio_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = GPIO_ADDR_WIDTH,
    parameter int DEBOUNCE_WIDTH = 8
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  gpio_sel,
    input  logic                  gpio_req,
    input  logic                  gpio_write,
    input  logic [ADDR_WIDTH-1:0] gpio_addr,
    input  logic [31:0]           gpio_wdata,
    output logic                  gpio_gnt,
    output logic                  gpio_rvalid,
    output logic [31:0]           gpio_rdata,
    input  logic [DATA_WIDTH-1:0] gpin,
    output logic [DATA_WIDTH-1:0] gpout,
    output logic [DATA_WIDTH-1:0] gpoe,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] out_q, dir_q, ien_q, rise_en_q, fall_en_q, stat_q;
    logic [DATA_WIDTH-1:0] level, rise, fall, w1c, stat_next;
    logic [31:0]           addr_ext, rd_word;
    logic [DATA_WIDTH-1:0] wd;
    logic                  access, wr, rd;
    logic                  unused_wdata;

`ifdef GPIO_DEBOUNCE_EN
    logic [DEBOUNCE_WIDTH-1:0] deb_q;
`endif

    assign access       = gpio_sel & gpio_req;
    assign wr           = access & gpio_write;
    assign rd           = access & ~gpio_write;
    assign gpio_gnt     = access;
    assign addr_ext     = 32'(gpio_addr);
    assign wd           = gpio_wdata[DATA_WIDTH-1:0];
    assign unused_wdata = ^gpio_wdata;

    gpio_sync_edge #(
        .DATA_WIDTH     (DATA_WIDTH),
        .DEBOUNCE_WIDTH (DEBOUNCE_WIDTH)
    ) u_sync_edge (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .gpin      (gpin),
`ifdef GPIO_DEBOUNCE_EN
        .deb_limit (deb_q),
`endif
        .level     (level),
        .rise      (rise),
        .fall      (fall)
    );

    // A new event on a bit overrides a W1C to that bit in the same cycle.
    always_comb begin
        w1c       = (wr && addr_ext == GPIO_OFF_IRQ_STAT) ? wd : '0;
        stat_next = (stat_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);
    end

    // NOTE: default assignment first so no path leaves rd_word unassigned (no latch).
    always_comb begin
        rd_word = '0;
        case (addr_ext)
            GPIO_OFF_IN:       rd_word = 32'(level);
            GPIO_OFF_OUT:      rd_word = 32'(out_q);
            GPIO_OFF_DIR:      rd_word = 32'(dir_q);
            GPIO_OFF_IRQ_EN:   rd_word = 32'(ien_q);
            GPIO_OFF_IRQ_RISE: rd_word = 32'(rise_en_q);
            GPIO_OFF_IRQ_FALL: rd_word = 32'(fall_en_q);
            GPIO_OFF_IRQ_STAT: rd_word = 32'(stat_q);
`ifdef GPIO_DEBOUNCE_EN
            GPIO_OFF_DEB:      rd_word = 32'(deb_q);
`endif
            default:           rd_word = '0;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            out_q       <= '0;
            dir_q       <= '0;
            ien_q       <= '0;
            rise_en_q   <= '0;
            fall_en_q   <= '0;
            stat_q      <= '0;
            irq         <= 1'b0;
            gpio_rvalid <= 1'b0;
            gpio_rdata  <= '0;
`ifdef GPIO_DEBOUNCE_EN
            deb_q       <= '0;
`endif
        end else begin
            gpio_rvalid <= access;
            gpio_rdata  <= rd ? rd_word : '0;
            stat_q      <= stat_next;
            irq         <= |(stat_q & ien_q);
            if (wr) begin
                case (addr_ext)
                    GPIO_OFF_OUT:      out_q     <= wd;
                    GPIO_OFF_DIR:      dir_q     <= wd;
                    GPIO_OFF_OUT_SET:  out_q     <= out_q | wd;
                    GPIO_OFF_OUT_CLR:  out_q     <= out_q & ~wd;
                    GPIO_OFF_OUT_TGL:  out_q     <= out_q ^ wd;
                    GPIO_OFF_IRQ_EN:   ien_q     <= wd;
                    GPIO_OFF_IRQ_RISE: rise_en_q <= wd;
                    GPIO_OFF_IRQ_FALL: fall_en_q <= wd;
`ifdef GPIO_DEBOUNCE_EN
                    GPIO_OFF_DEB:      deb_q     <= gpio_wdata[DEBOUNCE_WIDTH-1:0];
`endif
                    default: ;
                endcase
            end
        end
    end

    assign gpout = out_q;
    assign gpoe  = dir_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank; expected read responses are queued at issue and popped on rvalid.
// Honours GPIO_DEBOUNCE_EN (extra input latency and debounce scenario).
module tb_gpio_bank;
    import gpio_pkg::*;

    localparam int DW = 16;
`ifdef GPIO_DEBOUNCE_EN
    localparam int DL = 1;
`else
    localparam int DL = 0;
`endif

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          gpio_sel, gpio_req, gpio_write;
    logic [3:0]    gpio_addr;
    logic [31:0]   gpio_wdata;
    logic          gpio_gnt, gpio_rvalid;
    logic [31:0]   gpio_rdata;
    logic [DW-1:0] gpin, gpout, gpoe;
    logic          irq;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic [DW-1:0] out_m;

    gpio_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(4), .DEBOUNCE_WIDTH(8)) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .gpio_sel    (gpio_sel),
        .gpio_req    (gpio_req),
        .gpio_write  (gpio_write),
        .gpio_addr   (gpio_addr),
        .gpio_wdata  (gpio_wdata),
        .gpio_gnt    (gpio_gnt),
        .gpio_rvalid (gpio_rvalid),
        .gpio_rdata  (gpio_rdata),
        .gpin        (gpin),
        .gpout       (gpout),
        .gpoe        (gpoe),
        .irq         (irq)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns at the falling edge where the response is due.
    task automatic bus(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp, input string tag);
        logic [31:0] e;
        gpio_sel   = 1'b1;
        gpio_req   = 1'b1;
        gpio_write = wr;
        gpio_addr  = a[3:0];
        gpio_wdata = d;
        exp_q.push_back(wr ? 32'h0 : exp);
        #1 check({tag, "/gnt"}, 32'(gpio_gnt), 32'h1);
        @(posedge HCLK);
        @(negedge HCLK);
        gpio_sel = 1'b0;
        gpio_req = 1'b0;
        e = exp_q.pop_front();
        check({tag, "/rvalid"}, 32'(gpio_rvalid), 32'h1);
        check({tag, "/rdata"}, gpio_rdata, e);
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d, input string tag);
        bus(1'b1, a, d, 32'h0, tag);
    endtask

    task automatic rd_reg(input logic [31:0] a, input logic [31:0] exp, input string tag);
        bus(1'b0, a, 32'h0, exp, tag);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge HCLK);
    endtask

    initial begin
        HRESETn    = 1'b0;
        gpio_sel   = 1'b0;
        gpio_req   = 1'b0;
        gpio_write = 1'b0;
        gpio_addr  = '0;
        gpio_wdata = '0;
        gpin       = 16'hFFFF;
        out_m      = '0;

        // Reset state with all pads high
        idle(2);
        check("rst/gpout", 32'(gpout), 32'h0);
        check("rst/gpoe", 32'(gpoe), 32'h0);
        check("rst/irq", 32'(irq), 32'h0);
        check("rst/rvalid", 32'(gpio_rvalid), 32'h0);
        check("rst/rdata", gpio_rdata, 32'h0);
        @(posedge HCLK);
        #2 HRESETn = 1'b1;
        @(negedge HCLK);

        // Pins already high rise after reset once IRQ_RISE is set
        wr_reg(GPIO_OFF_IRQ_RISE, 32'h0000_FFFF, "rise_all");
        idle(3);
        rd_reg(GPIO_OFF_IRQ_STAT, 32'h0000_FFFF, "stat_after_rst");
        check("irq_not_enabled", 32'(irq), 32'h0);
        wr_reg(GPIO_OFF_IRQ_EN, 32'h0000_FFFF, "en_all");
        check("irq_en_lag", 32'(irq), 32'h0);
        idle(1);
        check("irq_en_high", 32'(irq), 32'h1);
        wr_reg(GPIO_OFF_IRQ_STAT, 32'h0000_FFFF, "w1c_all");
        check("irq_w1c_lag", 32'(irq), 32'h1);
        idle(1);
        check("irq_w1c_low", 32'(irq), 32'h0);
        wr_reg(GPIO_OFF_IRQ_EN, 32'h0, "en_off");
        wr_reg(GPIO_OFF_IRQ_RISE, 32'h0, "rise_off");
        rd_reg(GPIO_OFF_IRQ_STAT, 32'h0, "stat_clear");

        // Output register and atomic set/clear/toggle
        wr_reg(GPIO_OFF_OUT, 32'hABCD_00F0, "out_wr");
        out_m = 16'h00F0;
        check("gpout_wr", 32'(gpout), 32'(out_m));
        wr_reg(GPIO_OFF_OUT_SET, 32'h0000_0003, "out_set");
        out_m = out_m | 16'h0003;
        check("gpout_set", 32'(gpout), 32'(out_m));
        wr_reg(GPIO_OFF_OUT_CLR, 32'h0000_0010, "out_clr");
        out_m = out_m & ~16'h0010;
        check("gpout_clr", 32'(gpout), 32'(out_m));
        wr_reg(GPIO_OFF_OUT_TGL, 32'h0000_8001, "out_tgl");
        out_m = out_m ^ 16'h8001;
        check("gpout_tgl", 32'(gpout), 32'(out_m));
        rd_reg(GPIO_OFF_OUT, 32'h0000_80E2, "out_rd");
        idle(1);
        check("idle/rvalid", 32'(gpio_rvalid), 32'h0);
        check("idle/rdata", gpio_rdata, 32'h0);

        // Direction, unmapped offset, write-only read-back
        wr_reg(GPIO_OFF_DIR, 32'h0000_00FF, "dir_wr");
        check("gpoe_wr", 32'(gpoe), 32'h0000_00FF);
        rd_reg(GPIO_OFF_DIR, 32'h0000_00FF, "dir_rd");
        rd_reg(32'd15, 32'h0, "unmapped_rd");
        wr_reg(32'd15, 32'hFFFF_FFFF, "unmapped_wr");
        rd_reg(GPIO_OFF_OUT, 32'(out_m), "out_after_unmapped");
        rd_reg(GPIO_OFF_DIR, 32'h0000_00FF, "dir_after_unmapped");
        rd_reg(GPIO_OFF_OUT_SET, 32'h0, "wo_rd");
        check("gpout_hold", 32'(gpout), 32'(out_m));
        gpio_req = 1'b1;
        #1 check("gnt_no_sel", 32'(gpio_gnt), 32'h0);
        gpio_req = 1'b0;
        @(negedge HCLK);

        // Synchronised input read-back
        gpin = 16'h5A3C;
        idle(3 + DL);
        rd_reg(GPIO_OFF_IN, 32'h0000_5A3C, "in_rd");

        // Rise on pin 3: status at k+2, irq at k+3
        gpin = 16'hFFF7;
        idle(4 + DL);
        wr_reg(GPIO_OFF_IRQ_RISE, 32'h0000_0008, "rise3");
        wr_reg(GPIO_OFF_IRQ_EN, 32'h0000_0008, "en3");
        gpin[3] = 1'b1;
        for (int i = 0; i <= 2 + DL; i++) begin
            rd_reg(GPIO_OFF_IRQ_STAT, 32'h0, "stat3_early");
            check("irq3_early", 32'(irq), 32'h0);
        end
        rd_reg(GPIO_OFF_IRQ_STAT, 32'h0000_0008, "stat3_set");
        check("irq3_high", 32'(irq), 32'h1);
        wr_reg(GPIO_OFF_IRQ_STAT, 32'h0000_0008, "w1c3");
        check("irq3_lag", 32'(irq), 32'h1);
        idle(1);
        check("irq3_low", 32'(irq), 32'h0);
        rd_reg(GPIO_OFF_IRQ_STAT, 32'h0, "stat3_clr");

        // Set wins over a coincident W1C on pin 5 fall
        wr_reg(GPIO_OFF_IRQ_FALL, 32'h0000_0020, "fall5");
        gpin[5] = 1'b0;
        idle(4 + DL);
        rd_reg(GPIO_OFF_IRQ_STAT, 32'h0000_0020, "stat5_first");
        gpin[5] = 1'b1;
        idle(4 + DL);
        gpin[5] = 1'b0;
        idle(2 + DL);
        wr_reg(GPIO_OFF_IRQ_STAT, 32'h0000_0020, "w1c5_coincident");
        rd_reg(GPIO_OFF_IRQ_STAT, 32'h0000_0020, "stat5_kept");
        wr_reg(GPIO_OFF_IRQ_STAT, 32'h0000_0020, "w1c5");
        rd_reg(GPIO_OFF_IRQ_STAT, 32'h0, "stat5_clr");
        check("irq5_masked", 32'(irq), 32'h0);

`ifdef GPIO_DEBOUNCE_EN
        // Debounce: short pulse filtered, long pulse seen DEB_LIMIT+1 cycles after sync
        wr_reg(GPIO_OFF_DEB, 32'h0000_0004, "deb_wr");
        rd_reg(GPIO_OFF_DEB, 32'h0000_0004, "deb_rd");
        wr_reg(GPIO_OFF_IRQ_RISE, 32'h0000_0009, "rise0");
        gpin[0] = 1'b0;
        idle(12);
        wr_reg(GPIO_OFF_IRQ_STAT, 32'h0000_FFFF, "deb_w1c");
        gpin[0] = 1'b1;
        idle(3);
        gpin[0] = 1'b0;
        idle(12);
        rd_reg(GPIO_OFF_IRQ_STAT, 32'h0, "deb_short");
        gpin[0] = 1'b1;
        idle(7);
        rd_reg(GPIO_OFF_IRQ_STAT, 32'h0, "deb_long_early");
        rd_reg(GPIO_OFF_IRQ_STAT, 32'h0000_0001, "deb_long_set");
        idle(3);
        gpin[0] = 1'b0;
`else
        rd_reg(GPIO_OFF_DEB, 32'h0, "deb_unmapped");
`endif
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
